// File: rtl/seg7_scan_drv.sv
// Six-digit multiplexed 7-segment driver for the HH:MM:SS clock.
// Each digit gets one blank cycle and then SCAN_DIV shown cycles; the field being edited blinks.
module seg7_scan_drv #(
   parameter int SCAN_DIV   = 40000,
   parameter int BLINK_DIV  = 10000000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       CLOCK,
   input  logic       rst,
   input  logic [3:0] S0,
   input  logic [3:0] S1,
   input  logic [3:0] M0,
   input  logic [3:0] M1,
   input  logic [3:0] H0,
   input  logic [3:0] H1,
   input  logic [2:0] blink_sel,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   // Physical output levels: registers hold the pin value, already polarity-adjusted.
   localparam logic       POL     = ACTIVE_LOW;
   localparam logic [6:0] SEG_OFF = {7{POL}};
   localparam logic       DP_OFF  = POL;
   localparam logic [5:0] AN_OFF  = {6{POL}};

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t          r_state;
   logic [2:0]      r_idx;
   logic [PW-1:0]   r_presc;
   logic [BW-1:0]   r_blink_cnt;
   logic            r_blink_phase;
   logic [3:0]      r_digit;
   logic [6:0]      r_seg;
   logic            r_dp;
   logic [5:0]      r_an;

   logic [3:0]      w_digit_sel;
   logic            w_field_sel;
   logic            w_dp_pos;
   logic            w_blank;
   logic [5:0]      w_an_show;
   logic [6:0]      w_seg_show;
   logic            w_dp_show;

   function automatic logic [6:0] f_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_comb begin
      w_digit_sel = 4'd0;
      w_field_sel = 1'b0;
      w_dp_pos    = 1'b0;
      case (r_idx)
         3'd0: begin w_digit_sel = S0; w_field_sel = blink_sel[0]; end
         3'd1: begin w_digit_sel = S1; w_field_sel = blink_sel[0]; end
         3'd2: begin w_digit_sel = M0; w_field_sel = blink_sel[1]; w_dp_pos = 1'b1; end
         3'd3: begin w_digit_sel = M1; w_field_sel = blink_sel[1]; end
         3'd4: begin w_digit_sel = H0; w_field_sel = blink_sel[2]; w_dp_pos = 1'b1; end
         3'd5: begin w_digit_sel = H1; w_field_sel = blink_sel[2]; end
         default: begin
            w_digit_sel = 4'd0;
            w_field_sel = 1'b0;
            w_dp_pos    = 1'b0;
         end
      endcase
   end

   // blink_sel is live every cycle, so a field can start or stop blinking mid-digit.
   assign w_blank    = r_blink_phase & w_field_sel;
   assign w_an_show  = 6'd1 << r_idx;
   assign w_seg_show = w_blank ? 7'h00 : f_enc(r_digit);
   assign w_dp_show  = w_dp_pos & ~w_blank;

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         r_state <= ST_BLANK;
         r_idx   <= 3'd0;
         r_presc <= '0;
         r_an    <= AN_OFF;
         r_seg   <= SEG_OFF;
         r_dp    <= DP_OFF;
      end else begin
         case (r_state)
            ST_BLANK: begin
               r_an    <= AN_OFF;
               r_seg   <= SEG_OFF;
               r_dp    <= DP_OFF;
               r_state <= ST_SHOW;
            end
            ST_SHOW: begin
               r_an  <= w_an_show  ^ AN_OFF;
               r_seg <= w_seg_show ^ SEG_OFF;
               r_dp  <= w_dp_show  ^ DP_OFF;
               if (r_presc == SCAN_LAST) begin
                  r_presc <= '0;
                  r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                  r_state <= ST_BLANK;
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            default: begin
               r_state <= ST_BLANK;
               r_an    <= AN_OFF;
               r_seg   <= SEG_OFF;
               r_dp    <= DP_OFF;
            end
         endcase
      end
   end

   // Digit value is captured once per visit so mid-digit input changes never tear the display.
   always_ff @(posedge CLOCK) begin
      if (r_state == ST_BLANK)
         r_digit <= w_digit_sel;
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + BW'(1);
      end
   end

   assign seg = r_seg;
   assign dp  = r_dp;
   assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv: scan order, encoding, separators, blink, latching and polarity.
module tb_seg7_scan_drv;

   logic        CLOCK;
   logic        rst;
   logic [23:0] tb_dv;
   logic [2:0]  blink_sel;
   logic [6:0]  seg, seg_al;
   logic        dp, dp_al;
   logic [5:0]  an, an_al;
   int          n_chk;
   int          n_pass;

   seg7_scan_drv #(.SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b0)) dut (
      .CLOCK(CLOCK), .rst(rst),
      .S0(tb_dv[3:0]), .S1(tb_dv[7:4]), .M0(tb_dv[11:8]),
      .M1(tb_dv[15:12]), .H0(tb_dv[19:16]), .H1(tb_dv[23:20]),
      .blink_sel(blink_sel), .seg(seg), .dp(dp), .an(an)
   );

   seg7_scan_drv #(.SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b1)) dut_al (
      .CLOCK(CLOCK), .rst(rst),
      .S0(tb_dv[3:0]), .S1(tb_dv[7:4]), .M0(tb_dv[11:8]),
      .M1(tb_dv[15:12]), .H0(tb_dv[19:16]), .H1(tb_dv[23:20]),
      .blink_sel(blink_sel), .seg(seg_al), .dp(dp_al), .an(an_al)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // k = number of rising edges since reset release; output after edge k shows the
   // scan position of edge k-1 (period 5: one blank + four shown), blink phase flips every 16.
   function automatic logic [13:0] exp_at(input int k, input logic [2:0] sel,
                                          input logic [23:0] dv);
      int m, idx;
      logic [5:0] a;
      logic [6:0] s;
      logic p;
      m = k - 1;
      if (m % 5 == 0) return 14'd0;
      idx = (m / 5) % 6;
      a = 6'd1 << idx;
      s = enc(dv[idx*4 +: 4]);
      p = (idx == 2) || (idx == 4);
      if (((m / 16) % 2 == 1) && sel[idx/2]) begin
         s = 7'h00;
         p = 1'b0;
      end
      return {a, s, p};
   endfunction

   task automatic scan(input string tag, input logic [2:0] sel, input logic [23:0] dv,
                       input int kmax, input int chg_k, input logic [23:0] dv_late);
      logic [13:0] e;
      @(negedge CLOCK);
      tb_dv     = dv;
      blink_sel = sel;
      rst       = 1'b0;
      for (int k = 1; k <= kmax; k++) begin
         @(posedge CLOCK);
         @(negedge CLOCK);
         if (5 * ((k - 1) / 5) + 1 > chg_k && chg_k > 0) e = exp_at(k, sel, dv_late);
         else e = exp_at(k, sel, dv);
         chk($sformatf("%s_an_k%0d", tag, k), {26'd0, an}, {26'd0, e[13:8]});
         chk($sformatf("%s_seg_k%0d", tag, k), {25'd0, seg}, {25'd0, e[7:1]});
         chk($sformatf("%s_dp_k%0d", tag, k), {31'd0, dp}, {31'd0, e[0]});
         if (k == chg_k) tb_dv = dv_late;
      end
   endtask

   task automatic hit_rst(input string tag);
      #1 rst = 1'b1;
      #1;
      chk({tag, "_an"}, {26'd0, an}, 32'h00);
      chk({tag, "_seg"}, {25'd0, seg}, 32'h00);
      chk({tag, "_dp"}, {31'd0, dp}, 32'h0);
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rst       = 1'b1;
      blink_sel = 3'b000;
      tb_dv     = 24'h123456;
      repeat (3) @(negedge CLOCK);
      chk("rst_an", {26'd0, an}, 32'h00);
      chk("rst_seg", {25'd0, seg}, 32'h00);
      chk("rst_dp", {31'd0, dp}, 32'h0);
      chk("al_rst_an", {26'd0, an_al}, 32'h3F);
      chk("al_rst_seg", {25'd0, seg_al}, 32'h7F);
      chk("al_rst_dp", {31'd0, dp_al}, 32'h1);

      // full frame plus wrap, blink disabled across a phase-1 window
      scan("scan", 3'b000, 24'h123456, 40, 0, 24'h123456);
      hit_rst("rst_a");
      // stop mid-SHOW of idx3, reset, and require a clean restart
      scan("pre", 3'b000, 24'h123456, 18, 0, 24'h123456);
      chk("pre_an_idx3", {26'd0, an}, 32'h08);
      hit_rst("rst_mid");
      scan("restart", 3'b000, 24'h123456, 7, 0, 24'h123456);
      hit_rst("rst_b");

      scan("bcd", 3'b000, 24'h12F45A, 31, 0, 24'h12F45A);
      hit_rst("rst_c");
      scan("blink", 3'b010, 24'h123456, 70, 0, 24'h123456);
      hit_rst("rst_d");
      scan("blinkm", 3'b101, 24'h123456, 66, 0, 24'h123456);
      hit_rst("rst_e");
      scan("hold", 3'b000, 24'h123453, 36, 3, 24'h123454);
      hit_rst("rst_f");

      // active-low instance: digit 0 showing value 0
      @(negedge CLOCK);
      tb_dv = 24'h123450;
      chk("al_rst2_an", {26'd0, an_al}, 32'h3F);
      rst = 1'b0;
      @(posedge CLOCK);
      @(negedge CLOCK);
      chk("al_blank_an", {26'd0, an_al}, 32'h3F);
      chk("al_blank_seg", {25'd0, seg_al}, 32'h7F);
      chk("al_blank_dp", {31'd0, dp_al}, 32'h1);
      @(posedge CLOCK);
      @(negedge CLOCK);
      chk("al_d0_an", {26'd0, an_al}, 32'h3E);
      chk("al_d0_seg", {25'd0, seg_al}, 32'h40);
      chk("al_d0_dp", {31'd0, dp_al}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
